rxfifo: RTL

Receive buffer sitting directly downstream of `rxshift`: captures each byte `rxshift` presents on `o_Data` when its `o_Done` strobe rises and queues it in a small FIFO for the host-side reader. It provides first-word-fall-through read data, occupancy status and a sticky overrun flag, so the host can drain bytes at its own pace while reception continues at the baud rate.

---
 rtl/rxfifo_pkg.sv | 12 +
 rtl/rxfifo_if.sv | 30 +++
 rtl/rxfifo_mem.sv | 26 ++
 rtl/rxfifo.sv | 77 +++++++
 4 files changed

// File: rtl/rxfifo_pkg.sv
// Shared constants for the receive path: default FIFO depth and the byte width
// used by rxshift, txshift and rxfifo.
package rxfifo_pkg;

    localparam int RX_WIDTH = 8;
    localparam int RX_DEPTH = 8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rxfifo_if.sv
// Host-side bundle of rxfifo: byte capture inputs from rxshift, host pop/clear
// requests and the buffered read data with status flags.
interface rxfifo_if
    import rxfifo_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int WIDTH = RX_WIDTH
);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] i_Data;
    logic             i_Done;
    logic             i_Read;
    logic             i_Clear_Ovr;
    logic [WIDTH-1:0] o_Data;
    logic             o_Valid;
    logic             o_Full;
    logic [CW-1:0]    o_Count;
    logic             o_Overrun;

    modport slave (
        input  i_Data, i_Done, i_Read, i_Clear_Ovr,
        output o_Data, o_Valid, o_Full, o_Count, o_Overrun
    );

    modport master (
        output i_Data, i_Done, i_Read, i_Clear_Ovr,
        input  o_Data, o_Valid, o_Full, o_Count, o_Overrun
    );
endinterface

// File: rtl/rxfifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module rxfifo_mem
    import rxfifo_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int WIDTH = RX_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_Pclk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_Pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/rxfifo.sv
// Receive byte FIFO behind rxshift: one write per rising edge of i_Done,
// first-word-fall-through read, occupancy status and a sticky overrun flag.
module rxfifo
    import rxfifo_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int WIDTH = RX_WIDTH
) (
    input  logic   i_Pclk,
    input  logic   i_Reset,
    rxfifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          r_Done_d;
    logic          overrun;

    logic empty, full, wr_evt, rd_evt, wr_ok, drop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign wr_evt = bus.i_Done & ~r_Done_d;
    assign rd_evt = bus.i_Read & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign wr_ok  = wr_evt & (~full | rd_evt);
    assign drop   = wr_evt & full & ~rd_evt;

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            r_Done_d <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            r_Done_d <= bus.i_Done;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_evt) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_evt) begin
                count <= count + 1'b1;
            end else if (rd_evt && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (bus.i_Clear_Ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    rxfifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .i_Pclk  (i_Pclk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_Data),
        .rd_addr (rd_ptr),
        .rd_data (bus.o_Data)
    );

    assign bus.o_Valid   = ~empty;
    assign bus.o_Full    = full;
    assign bus.o_Count   = count;
    assign bus.o_Overrun = overrun;
endmodule
